// File: rtl/mcdf_core_pkg.sv
// Shared types, widths, register map and helpers for the multi-channel data formatter.
package mcdf_core_pkg;

    localparam int unsigned ADDR_WIDTH     = 8;
    localparam int unsigned CMD_DATA_WIDTH = 32;
    localparam int unsigned CH_DATA_WIDTH  = 32;
    localparam int unsigned FIFO_DEPTH     = 32;
    localparam int unsigned NUM_CH         = 3;
    localparam int unsigned CNT_WIDTH      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEN_WIDTH      = 6;
    localparam int unsigned CHID_WIDTH     = 2;
    localparam int unsigned CTRL_WIDTH     = 6;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } cmd_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL_BASE   = 8'h00;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MARGIN_BASE = 8'h10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STRIDE      = 8'h04;

    localparam logic [CMD_DATA_WIDTH-1:0] CTRL_RST_VAL = 32'h0000_0007;

    typedef struct packed {
        logic [2:0] len_code;
        logic [1:0] prio;
        logic       en;
    } ctrl_reg_t;

    typedef enum logic [1:0] {
        FMT_IDLE,
        FMT_REQ,
        FMT_SEND,
        FMT_GAP
    } fmt_state_e;

    function automatic logic [LEN_WIDTH-1:0] pkt_len(input logic [2:0] code);
        case (code)
            3'd0:    return 6'd4;
            3'd1:    return 6'd8;
            3'd2:    return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input int unsigned idx);
        return base + ADDR_WIDTH'(idx) * ADDR_STRIDE;
    endfunction

endpackage

// File: rtl/multi_chnl_data_fmt_if.sv
// Command, channel and packet-formatter signal bundle of the MCDF core.
interface multi_chnl_data_fmt_if;
    import mcdf_core_pkg::*;

    logic [1:0]                cmd_i;
    logic [ADDR_WIDTH-1:0]     cmd_addr_i;
    logic [CMD_DATA_WIDTH-1:0] cmd_data_i;
    logic [CMD_DATA_WIDTH-1:0] cmd_data_o;

    logic [CH_DATA_WIDTH-1:0]  ch0_data_i, ch1_data_i, ch2_data_i;
    logic                      ch0_vld_i, ch1_vld_i, ch2_vld_i;
    logic                      ch0_ready_o, ch1_ready_o, ch2_ready_o;

    logic                      fmt_grant_i;
    logic [CHID_WIDTH-1:0]     fmt_chid_o;
    logic                      fmt_req_o;
    logic [LEN_WIDTH-1:0]      fmt_length_o;
    logic [CH_DATA_WIDTH-1:0]  fmt_data_o;
    logic                      fmt_start_o;
    logic                      fmt_end_o;

    // Environment side: drives commands, channel words and grant.
    modport master (
        output cmd_i, cmd_addr_i, cmd_data_i,
        output ch0_data_i, ch1_data_i, ch2_data_i, ch0_vld_i, ch1_vld_i, ch2_vld_i,
        output fmt_grant_i,
        input  cmd_data_o, ch0_ready_o, ch1_ready_o, ch2_ready_o,
        input  fmt_chid_o, fmt_req_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o
    );

    // Core side.
    modport slave (
        input  cmd_i, cmd_addr_i, cmd_data_i,
        input  ch0_data_i, ch1_data_i, ch2_data_i, ch0_vld_i, ch1_vld_i, ch2_vld_i,
        input  fmt_grant_i,
        output cmd_data_o, ch0_ready_o, ch1_ready_o, ch2_ready_o,
        output fmt_chid_o, fmt_req_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o
    );

endinterface

// File: rtl/chnl_fifo.sv
// Synchronous per-channel FIFO with occupancy count; pushes when full and pops when empty are dropped.
module chnl_fifo
    import mcdf_core_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned WIDTH = CH_DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_c, do_pop_c;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem[rd_ptr_q];
    assign do_push_c = push && !full;
    assign do_pop_c  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (do_push_c) mem[wr_ptr_q] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/multi_chnl_data_fmt.sv
// MCDF core: three channel FIFOs, priority arbiter, packet formatter and control registers.
// Optional MCDF_FIFO_MARGIN_RO_EN maps read-only FIFO free-margin registers at 0x10/0x14/0x18.
module multi_chnl_data_fmt
    import mcdf_core_pkg::*;
(
    input logic                  clk_i,
    input logic                  rstn_i,
    multi_chnl_data_fmt_if.slave bus
);

    logic [CH_DATA_WIDTH-1:0]  ch_data   [NUM_CH];
    logic [CH_DATA_WIDTH-1:0]  fifo_head [NUM_CH];
    logic [CNT_WIDTH-1:0]      fifo_count[NUM_CH];
    logic [NUM_CH-1:0]         ch_vld, ch_ready, ch_req;
    logic [NUM_CH-1:0]         fifo_push, fifo_pop, fifo_full, fifo_empty;
    ctrl_reg_t                 ctrl_q    [NUM_CH];
    logic [CMD_DATA_WIDTH-1:0] rd_data_c, cmd_data_q;

    fmt_state_e                state_q;
    logic [CHID_WIDTH-1:0]     chid_q, win_chid_c;
    logic [LEN_WIDTH-1:0]      len_q, win_len_c, word_cnt_q;
    logic [1:0]                best_prio_c;
    logic                      win_vld_c, pop_c;
    logic                      fmt_req_q, fmt_start_q, fmt_end_q;
    logic [CH_DATA_WIDTH-1:0]  fmt_data_q, head_c;
    logic                      unused_cmd_bits;

    assign ch_data = '{bus.ch0_data_i, bus.ch1_data_i, bus.ch2_data_i};
    assign ch_vld  = {bus.ch2_vld_i, bus.ch1_vld_i, bus.ch0_vld_i};
    assign unused_cmd_bits = ^bus.cmd_data_i[CMD_DATA_WIDTH-1:CTRL_WIDTH];

    assign bus.ch0_ready_o  = ch_ready[0];
    assign bus.ch1_ready_o  = ch_ready[1];
    assign bus.ch2_ready_o  = ch_ready[2];
    assign bus.cmd_data_o   = cmd_data_q;
    assign bus.fmt_req_o    = fmt_req_q;
    assign bus.fmt_chid_o   = chid_q;
    assign bus.fmt_length_o = len_q;
    assign bus.fmt_data_o   = fmt_data_q;
    assign bus.fmt_start_o  = fmt_start_q;
    assign bus.fmt_end_o    = fmt_end_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_ready[i]  = ctrl_q[i].en && !fifo_full[i];
        assign fifo_push[i] = ch_vld[i] && ch_ready[i];
        assign fifo_pop[i]  = pop_c && (chid_q == CHID_WIDTH'(i)) && !fifo_empty[i];
        assign ch_req[i]    = ctrl_q[i].en &&
                              (fifo_count[i] >= CNT_WIDTH'(pkt_len(ctrl_q[i].len_code)));

        chnl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CH_DATA_WIDTH)) u_fifo (
            .clk_i (clk_i),
            .rstn_i(rstn_i),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .wdata (ch_data[i]),
            .rdata (fifo_head[i]),
            .count (fifo_count[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Register read mux; unmapped addresses return zero.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.cmd_addr_i == reg_addr(ADDR_CTRL_BASE, i))
                rd_data_c = CMD_DATA_WIDTH'(ctrl_q[i]);
`ifdef MCDF_FIFO_MARGIN_RO_EN
            if (bus.cmd_addr_i == reg_addr(ADDR_MARGIN_BASE, i))
                rd_data_c = CMD_DATA_WIDTH'(8'(FIFO_DEPTH - 32'(fifo_count[i])));
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                ctrl_q[i] <= ctrl_reg_t'(CTRL_RST_VAL[CTRL_WIDTH-1:0]);
            cmd_data_q <= '0;
        end else begin
            if (bus.cmd_i == CMD_WRITE) begin
                for (int unsigned i = 0; i < NUM_CH; i++)
                    if (bus.cmd_addr_i == reg_addr(ADDR_CTRL_BASE, i))
                        ctrl_q[i] <= ctrl_reg_t'(bus.cmd_data_i[CTRL_WIDTH-1:0]);
            end
            if (bus.cmd_i == CMD_READ) cmd_data_q <= rd_data_c;
        end
    end

    // Lowest prio value wins; strict compare keeps ties on the lowest channel id.
    always_comb begin
        win_vld_c   = 1'b0;
        win_chid_c  = '0;
        win_len_c   = '0;
        best_prio_c = '1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_req[i] && (!win_vld_c || ctrl_q[i].prio < best_prio_c)) begin
                win_vld_c   = 1'b1;
                win_chid_c  = CHID_WIDTH'(i);
                best_prio_c = ctrl_q[i].prio;
                win_len_c   = pkt_len(ctrl_q[i].len_code);
            end
        end
    end

    always_comb begin
        head_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (chid_q == CHID_WIDTH'(i)) head_c = fifo_head[i];
    end

    // Word 0 is popped on the grant edge so it is on the bus the cycle after grant.
    assign pop_c = ((state_q == FMT_REQ) && bus.fmt_grant_i) ||
                   ((state_q == FMT_SEND) && (word_cnt_q < len_q));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= FMT_IDLE;
            chid_q      <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            fmt_req_q   <= 1'b0;
            fmt_start_q <= 1'b0;
            fmt_end_q   <= 1'b0;
            fmt_data_q  <= '0;
        end else begin
            case (state_q)
                FMT_IDLE: begin
                    if (win_vld_c) begin
                        chid_q    <= win_chid_c;
                        len_q     <= win_len_c;
                        fmt_req_q <= 1'b1;
                        state_q   <= FMT_REQ;
                    end
                end
                FMT_REQ: begin
                    if (bus.fmt_grant_i) begin
                        fmt_req_q   <= 1'b0;
                        fmt_start_q <= 1'b1;
                        fmt_end_q   <= (len_q == LEN_WIDTH'(1));
                        fmt_data_q  <= head_c;
                        word_cnt_q  <= LEN_WIDTH'(1);
                        state_q     <= FMT_SEND;
                    end
                end
                FMT_SEND: begin
                    fmt_start_q <= 1'b0;
                    if (word_cnt_q < len_q) begin
                        fmt_end_q  <= (word_cnt_q == len_q - LEN_WIDTH'(1));
                        fmt_data_q <= head_c;
                        word_cnt_q <= word_cnt_q + LEN_WIDTH'(1);
                    end else begin
                        fmt_end_q  <= 1'b0;
                        fmt_data_q <= '0;
                        state_q    <= FMT_GAP;
                    end
                end
                FMT_GAP:  state_q <= FMT_IDLE;
                default:  state_q <= FMT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_chnl_data_fmt.sv
// Directed plus randomized bench for multi_chnl_data_fmt against a queue-based reference model.
module tb_multi_chnl_data_fmt;
    import mcdf_core_pkg::*;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;

    multi_chnl_data_fmt_if bus();

    multi_chnl_data_fmt dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: control fields per channel and the words each FIFO should hold.
    logic [5:0]  regm [3];
    logic [31:0] mq   [3][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input logic [2:0] code);
        return (code >= 3'd3) ? 32 : (4 << code);
    endfunction

    function automatic int model_arb();
        int best = -1;
        for (int i = 0; i < 3; i++)
            if (regm[i][0] && mq[i].size() >= len_of(regm[i][5:3]) &&
                (best < 0 || regm[i][2:1] < regm[best][2:1]))
                best = i;
        return best;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (a == 8'(4 * i)) r = {26'h0, regm[i]};
`ifdef MCDF_FIFO_MARGIN_RO_EN
            if (a == 8'(16 + 4 * i)) r = 32'(32 - mq[i].size());
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            regm[i] = 6'h07;
            mq[i].delete();
        end
    endtask

    task automatic set_ch(input int i, input logic vld, input logic [31:0] d);
        case (i)
            0:       begin bus.ch0_vld_i = vld; bus.ch0_data_i = d; end
            1:       begin bus.ch1_vld_i = vld; bus.ch1_data_i = d; end
            default: begin bus.ch2_vld_i = vld; bus.ch2_data_i = d; end
        endcase
    endtask

    function automatic logic get_ready(input int i);
        case (i)
            0:       return bus.ch0_ready_o;
            1:       return bus.ch1_ready_o;
            default: return bus.ch2_ready_o;
        endcase
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.cmd_i = 2'b10; bus.cmd_addr_i = a; bus.cmd_data_i = d;
        @(posedge clk_i); #1;
        bus.cmd_i = 2'b00;
        for (int i = 0; i < 3; i++)
            if (a == 8'(4 * i)) regm[i] = d[5:0];
    endtask

    task automatic do_read(input logic [7:0] a, input string tag);
        logic [31:0] exp;
        @(negedge clk_i);
        bus.cmd_i = 2'b01; bus.cmd_addr_i = a;
        exp = model_read(a);
        @(posedge clk_i); #1;
        bus.cmd_i = 2'b00;
        @(negedge clk_i);
        check(tag, bus.cmd_data_o, exp);
    endtask

    // One cycle of channel traffic: each masked channel offers one word.
    task automatic push_cycle(input logic [2:0] mask, input bit fixed, input logic [31:0] val);
        logic [31:0] d [3];
        logic        exp_rdy;
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            d[i] = fixed ? val : $urandom;
            set_ch(i, mask[i], d[i]);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_rdy = regm[i][0] && (mq[i].size() < 32);
            check($sformatf("ch%0d_ready", i), 32'(get_ready(i)), 32'(exp_rdy));
            if (mask[i] && exp_rdy) mq[i].push_back(d[i]);
        end
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) set_ch(i, 1'b0, 32'h0);
    endtask

    task automatic run_packet(input int gdelay);
        int          exp_ch, exp_len;
        logic        seen;
        logic [31:0] exp_data;
        exp_ch = model_arb();
        if (exp_ch < 0) exp_ch = 0;
        exp_len = len_of(regm[exp_ch][5:3]);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk_i);
            seen = bus.fmt_req_o;
        end
        check("req_wait", 32'(seen), 32'd1);
        if (!seen) return;
        check("req_chid", 32'(bus.fmt_chid_o), 32'(exp_ch));
        check("req_length", 32'(bus.fmt_length_o), 32'(exp_len));
        for (int g = 0; g < gdelay; g++) begin
            @(negedge clk_i);
            check("req_hold", 32'(bus.fmt_req_o), 32'd1);
            check("req_hold_chid", 32'(bus.fmt_chid_o), 32'(exp_ch));
        end
        bus.fmt_grant_i = 1'b1;
        @(posedge clk_i); #1;
        bus.fmt_grant_i = 1'b0;
        for (int w = 0; w < exp_len; w++) begin
            @(negedge clk_i);
            exp_data = mq[exp_ch].pop_front();
            check($sformatf("data_ch%0d_w%0d", exp_ch, w), bus.fmt_data_o, exp_data);
            check("start", 32'(bus.fmt_start_o), 32'(w == 0));
            check("end", 32'(bus.fmt_end_o), 32'(w == exp_len - 1));
            if (w == 0) check("req_drop", 32'(bus.fmt_req_o), 32'd0);
        end
        @(negedge clk_i);
        check("gap_start", 32'(bus.fmt_start_o), 32'd0);
        check("gap_end", 32'(bus.fmt_end_o), 32'd0);
        check("gap_req", 32'(bus.fmt_req_o), 32'd0);
        check("gap_data", bus.fmt_data_o, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bus.cmd_i = 2'b00; bus.cmd_addr_i = '0; bus.cmd_data_i = '0;
        bus.fmt_grant_i = 1'b0;
        for (int i = 0; i < 3; i++) set_ch(i, 1'b0, 32'h0);
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_ready0", 32'(bus.ch0_ready_o), 32'd1);
        check("rst_ready1", 32'(bus.ch1_ready_o), 32'd1);
        check("rst_ready2", 32'(bus.ch2_ready_o), 32'd1);
        check("rst_req", 32'(bus.fmt_req_o), 32'd0);
        check("rst_start", 32'(bus.fmt_start_o), 32'd0);
        check("rst_cmd_data", bus.cmd_data_o, 32'd0);
        rstn_i = 1'b1;
        do_read(8'h00, "rd_reg0");
        do_read(8'h04, "rd_reg1");
        do_read(8'h08, "rd_reg2");
        do_read(8'h10, "rd_margin0");
        do_read(8'h0C, "rd_unmapped");

        // Upper register bits and margin writes are ignored
        do_write(8'h00, 32'hFFFF_FFC0 | 32'h0B);
        do_write(8'h10, 32'hFF);
        do_read(8'h00, "rd_reg0_masked");
        do_read(8'h10, "rd_margin_after_wr");

        // ch0, len 8, words 1..8, immediate grant
        for (int w = 1; w <= 8; w++) push_cycle(3'b001, 1'b1, 32'(w));
        run_packet(0);

        // Equal priority round: ch0, ch1, ch2
        do_write(8'h00, 32'h07);
        do_write(8'h04, 32'h07);
        do_write(8'h08, 32'h07);
        for (int c = 0; c < 3; c++)
            for (int w = 0; w < 4; w++) push_cycle(3'(1 << c), 1'b0, 32'h0);
        for (int p = 0; p < 3; p++) run_packet(p);

        // Priority: ch2 prio0, ch1 prio1, ch0 prio3, all reach length together
        do_write(8'h00, 32'h07);
        do_write(8'h04, 32'h03);
        do_write(8'h08, 32'h01);
        for (int w = 0; w < 4; w++) push_cycle(3'b111, 1'b0, 32'h0);
        for (int p = 0; p < 3; p++) run_packet(1);

        // Randomized priorities and traffic
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 3; i++) begin
                d = $urandom;
                d[0] = 1'b1;
                d[5:3] = 3'b000;
                do_write(8'(4 * i), d);
            end
            for (int c = 0; c < 40 && model_arb() < 0; c++)
                push_cycle(3'($urandom_range(1, 7)), 1'b0, 32'h0);
            run_packet($urandom_range(0, 3));
            for (int k = 0; k < 4 && model_arb() >= 0; k++) run_packet($urandom_range(0, 2));
        end

        // Disable ch1: ready drops next cycle, offered words are dropped
        do_write(8'h04, 32'h06);
        @(negedge clk_i);
        check("ch1_ready_disabled", 32'(bus.ch1_ready_o), 32'd0);
        for (int w = 0; w < 3; w++) push_cycle(3'b010, 1'b0, 32'h0);
        do_write(8'h04, 32'h07);
        for (int w = 0; w < 4; w++) push_cycle(3'b010, 1'b0, 32'h0);
        run_packet(1);

        // Fill ch0 to 32 words without grant
        do_write(8'h00, 32'h1F);
        for (int c = 0; c < 40 && mq[0].size() < 32; c++) push_cycle(3'b001, 1'b0, 32'h0);
        push_cycle(3'b001, 1'b0, 32'h0);
        check("ch0_ready_full", 32'(bus.ch0_ready_o), 32'd0);
        do_read(8'h10, "rd_margin_full");
        run_packet(2);
        do_read(8'h10, "rd_margin_drained");

        // Reset in the middle of a packet
        do_write(8'h00, 32'h07);
        for (int c = 0; c < 8 && model_arb() < 0; c++) push_cycle(3'b001, 1'b0, 32'h0);
        for (int t = 0; t < 20 && !bus.fmt_req_o; t++) @(negedge clk_i);
        bus.fmt_grant_i = 1'b1;
        @(posedge clk_i); #1;
        bus.fmt_grant_i = 1'b0;
        @(negedge clk_i);
        check("mid_start", 32'(bus.fmt_start_o), 32'd1);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        check("abort_data", bus.fmt_data_o, 32'd0);
        check("abort_req", 32'(bus.fmt_req_o), 32'd0);
        check("abort_start", 32'(bus.fmt_start_o), 32'd0);
        check("abort_end", 32'(bus.fmt_end_o), 32'd0);
        check("abort_length", 32'(bus.fmt_length_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_read(8'h00, "rd_reg0_after_abort");
        do_read(8'h10, "rd_margin_after_abort");
        for (int w = 0; w < 4; w++) push_cycle(3'b100, 1'b0, 32'h0);
        run_packet(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
